// File: rtl/spram_fifo_pkg.sv
// Shared types and width helpers for the single-port-RAM FIFO family.
// Reused by the bank FIFO and its ping-pong wrapper.
package spram_fifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_WR,
        OP_RD
    } op_t;

    // Bits needed to count 0..n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spram_1p.sv
// Single-port RAM model: one read or one write per cycle.
// Registered read data, no reset; replaced by the foundry macro.
module spram_1p #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata <= mem_q[addr];
            end
        end
    end

endmodule

// File: rtl/spram_bank_fifo.sv
// Valid/ready FIFO on one single-port RAM with a prefetching
// output buffer so the head is always served from flops.
module spram_bank_fifo
    import spram_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 32,
    parameter int OB_DEPTH   = 3,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH+1:0] occupancy
);

    localparam int RCW = ADDR_WIDTH + 1;
    localparam int OCW = cnt_w(OB_DEPTH);
    localparam int OPW = ptr_w(OB_DEPTH);
    localparam int OCC = ADDR_WIDTH + 2;

    localparam logic [RCW-1:0] RAM_FULL = RCW'(FIFO_DEPTH);
    localparam logic [OCW:0]   OB_FULL  = (OCW + 1)'(OB_DEPTH);
    localparam logic [OPW-1:0] OB_LAST  = OPW'(OB_DEPTH - 1);

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [RCW-1:0]        ram_cnt_q, ram_cnt_d;
    logic                  rd_inflight_q;
    logic [OCW-1:0]        ob_cnt_q, ob_cnt_d;
    logic [OPW-1:0]        ob_head_q, ob_head_d;
    logic [OPW-1:0]        ob_tail_q, ob_tail_d;
    logic [DATA_WIDTH-1:0] ob_q [OB_DEPTH];

    logic                  rd_issue;
    logic                  accept;
    logic                  bypass;
    logic                  pop;
    logic                  push;
    op_t                   op;
    logic [DATA_WIDTH-1:0] push_data;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [ADDR_WIDTH-1:0] ram_addr;

    function automatic logic [OPW-1:0] ob_inc(input logic [OPW-1:0] p);
        return (p == OB_LAST) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        // Free OB slots must cover any read already in flight.
        rd_issue = (ram_cnt_q != '0) &&
                   (({1'b0, ob_cnt_q} + (OCW + 1)'(rd_inflight_q)) < OB_FULL);
        in_ready = !rd_issue && (ram_cnt_q < RAM_FULL);
        accept   = in_valid && in_ready;
        bypass   = accept && (ram_cnt_q == '0) && !rd_inflight_q &&
                   ({1'b0, ob_cnt_q} < OB_FULL);
        pop      = out_valid && out_ready;
        push     = rd_inflight_q || bypass;

        op = OP_IDLE;
        unique case (1'b1)
            rd_issue:          op = OP_RD;
            (accept && !bypass): op = OP_WR;
            default:           op = OP_IDLE;
        endcase

        push_data = rd_inflight_q ? ram_rdata : in_data;
        ram_addr  = (op == OP_RD) ? rd_ptr_q : wr_ptr_q;

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (op == OP_WR) begin
            wr_ptr_d  = wr_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q + 1'b1;
        end
        if (op == OP_RD) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        ob_head_d = pop  ? ob_inc(ob_head_q) : ob_head_q;
        ob_tail_d = push ? ob_inc(ob_tail_q) : ob_tail_q;
        ob_cnt_d  = ob_cnt_q + OCW'(push) - OCW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            ram_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            ob_cnt_q      <= '0;
            ob_head_q     <= '0;
            ob_tail_q     <= '0;
            for (int i = 0; i < OB_DEPTH; i++) begin
                ob_q[i] <= '0;
            end
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            ram_cnt_q     <= ram_cnt_d;
            rd_inflight_q <= (op == OP_RD);
            ob_cnt_q      <= ob_cnt_d;
            ob_head_q     <= ob_head_d;
            ob_tail_q     <= ob_tail_d;
            if (push) begin
                ob_q[ob_tail_q] <= push_data;
            end
        end
    end

    assign out_valid = (ob_cnt_q != '0);
    assign out_data  = ob_q[ob_head_q];
    assign occupancy = OCC'(ram_cnt_q) + OCC'(rd_inflight_q) + OCC'(ob_cnt_q);

    spram_1p #(
        .DW(DATA_WIDTH),
        .AW(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (op != OP_IDLE),
        .we   (op == OP_WR),
        .addr (ram_addr),
        .wdata(in_data),
        .rdata(ram_rdata)
    );

endmodule
